video_scanout: RTL and testbench

VIDEO_SCANOUT -- requirements
Module: video_scanout

---
 rtl/video_scanout.sv | 155 +++++++++++++++
 tb/tb_video_scanout.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_scanout.sv
`default_nettype none
// ============================================================================
// Module  : video_scanout
// Brief   : Raster timing generator that scans 8-bit pixel indices out of a
//           64-bit-wide video SRAM port, one 8-pixel group per fetch.
// Rev     : 1.0 - initial release
// ============================================================================
module video_scanout #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 4,
    parameter int   STRIDE   = 640,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] base_addr,
    output logic [23:0] video_addr,
    input  logic [63:0] video_dout,
    output logic [7:0]  pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_ce
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);
    localparam int c_DW      = $clog2(CLK_DIV);

    localparam logic [c_DW-1:0] c_DIV_LAST     = c_DW'(CLK_DIV - 1);
    localparam logic [c_HW-1:0] c_H_ACT        = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_SYNC_START = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_H_SYNC_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_H_LAST       = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT        = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_ACT_LAST   = c_VW'(V_ACTIVE - 1);
    localparam logic [c_VW-1:0] c_V_SYNC_START = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_V_SYNC_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST       = c_VW'(c_V_TOTAL - 1);
    localparam logic [23:0]     c_STRIDE       = 24'(STRIDE) & ~24'h7;

    logic [c_DW-1:0] r_div;
    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;
    logic [23:0]     r_addr;
    logic [23:0]     r_line_base;
    logic [63:0]     r_hold;
    logic [7:0]      r_pixel;
    logic            r_de;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_pix_ce;

    logic            w_ce;
    logic            w_de;
    logic            w_hs_on;
    logic            w_vs_on;
    logic            w_group_start;
    logic            w_line_end;
    logic [23:0]     w_base;
    logic [23:0]     w_next_line;
    logic [7:0]      w_hold_byte;
    logic            w_unused;

    assign w_ce          = (r_div == c_DIV_LAST);
    assign w_de          = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs_on       = (r_h >= c_H_SYNC_START) && (r_h < c_H_SYNC_END);
    assign w_vs_on       = (r_v >= c_V_SYNC_START) && (r_v < c_V_SYNC_END);
    assign w_group_start = (r_h[2:0] == 3'd0);
    assign w_line_end    = (r_h == c_H_ACT);
    assign w_base        = {base_addr[23:3], 3'b000};
    assign w_next_line   = r_line_base + c_STRIDE;
    assign w_hold_byte   = r_hold[{r_h[2:0], 3'b000} +: 8];
    assign w_unused      = ^base_addr[2:0];

    // All per-pixel outputs are computed from the pre-increment h/v so they
    // line up with the pix_ce pulse that is registered on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_h         <= c_H_ACT;
            r_v         <= c_V_LAST;
            r_addr      <= '0;
            r_line_base <= '0;
            r_hold      <= '0;
            r_pixel     <= '0;
            r_de        <= 1'b0;
            r_hsync     <= ~HS_POL;
            r_vsync     <= ~VS_POL;
            r_pix_ce    <= 1'b0;
        end else begin
            r_pix_ce <= w_ce;
            if (w_ce) begin
                r_div <= '0;
                if (r_h == c_H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end

                r_de    <= w_de;
                r_hsync <= w_hs_on ? HS_POL : ~HS_POL;
                r_vsync <= w_vs_on ? VS_POL : ~VS_POL;

                // The fetch address moves on as soon as a group is captured,
                // giving the SRAM a full group time to return the next one.
                if (w_de) begin
                    if (w_group_start) begin
                        r_pixel <= video_dout[7:0];
                        r_hold  <= video_dout;
                        r_addr  <= r_addr + 24'd8;
                    end else begin
                        r_pixel <= w_hold_byte;
                    end
                end else begin
                    r_pixel <= '0;
                end

                // Line bases are only loaded in horizontal blanking, so the
                // frame base is sampled once per frame.
                if (w_line_end) begin
                    if (r_v == c_V_LAST) begin
                        r_line_base <= w_base;
                        r_addr      <= w_base;
                    end else if (r_v < c_V_ACT_LAST) begin
                        r_line_base <= w_next_line;
                        r_addr      <= w_next_line;
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign video_addr = r_addr;
    assign pixel      = r_pixel;
    assign de         = r_de;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign pix_ce     = r_pix_ce;

endmodule
`default_nettype wire

// File: tb/tb_video_scanout.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_scanout
// Brief   : Scoreboard bench for video_scanout on a reduced raster with a
//           6-clock-latency SRAM model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_video_scanout;

    localparam int   HA  = 16;
    localparam int   HFP = 2;
    localparam int   HSW = 3;
    localparam int   HBP = 3;
    localparam int   VA  = 4;
    localparam int   VFP = 1;
    localparam int   VSW = 2;
    localparam int   VBP = 1;
    localparam int   DIV = 4;
    localparam int   STR = 32;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int   HT  = HA + HFP + HSW + HBP;
    localparam int   VT  = VA + VFP + VSW + VBP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] base_addr = 24'h010000;
    logic [23:0] video_addr;
    logic [63:0] video_dout;
    logic [7:0]  pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        pix_ce;

    video_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(DIV), .STRIDE(STR), .HS_POL(HSP), .VS_POL(VSP)
    ) u_dut (
        .clk(clk), .rst(rst), .base_addr(base_addr), .video_addr(video_addr),
        .video_dout(video_dout), .pixel(pixel), .de(de), .hsync(hsync),
        .vsync(vsync), .pix_ce(pix_ce)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the byte address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ (a[15:8] + 8'h5A) ^ {a[19:16], a[23:20]};
    endfunction

    logic [23:0] r_pipe [6];
    always @(posedge clk) begin
        r_pipe[0] <= video_addr;
        for (int i = 1; i < 6; i++) r_pipe[i] <= r_pipe[i-1];
    end

    always_comb begin
        video_dout = '0;
        for (int k = 0; k < 8; k++) video_dout[8*k +: 8] = mem_byte(r_pipe[5] + 24'(k));
    end

    typedef struct {
        int          h;
        int          v;
        logic [7:0]  pix;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] addr;
    } exp_t;

    exp_t q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    logic        done  = 1'b0;

    int          m_h;
    int          m_v;
    logic [23:0] m_addr;
    logic [23:0] m_lb;
    logic [23:0] m_next;

    task automatic model_reset();
        m_h    = HA;
        m_v    = VT - 1;
        m_addr = '0;
        m_lb   = '0;
    endtask

    task automatic push_n(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.h  = m_h;
            e.v  = m_v;
            e.de = (m_h < HA) && (m_v < VA);
            e.hs = (m_h >= HA + HFP && m_h < HA + HFP + HSW) ? HSP : ~HSP;
            e.vs = (m_v >= VA + VFP && m_v < VA + VFP + VSW) ? VSP : ~VSP;
            e.pix = e.de ? mem_byte(m_lb + 24'(m_h)) : 8'h00;
            if (e.de && (m_h % 8) == 0) m_addr = m_lb + 24'(m_h + 8);
            if (m_h == HA) begin
                if (m_v == VT - 1) begin
                    m_lb   = m_next & 24'hFFFFF8;
                    m_addr = m_lb;
                end else if (m_v < VA - 1) begin
                    m_lb   = m_lb + 24'(STR);
                    m_addr = m_lb;
                end
            end
            e.addr = m_addr;
            q.push_back(e);
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
    endtask

    task automatic wait_pop(input int target);
        for (int i = 0; i < 4000 && n_pop < target; i++) @(negedge clk);
    endtask

    // Stimulus: pushes expectations ahead and steers base_addr / rst.
    initial begin
        model_reset();
        m_next = 24'h010000;  push_n(8);
        m_next = 24'h020000;  push_n(HT * VT);
        m_next = 24'hFFFFF3;  push_n(HT * VT);
        m_next = 24'h000100;  push_n(HT * VT);
        push_n(2 * HT + 11);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_pop(8 + 2 * HT);
        base_addr = 24'h020000;
        wait_pop(8 + HT * VT + 2 * HT);
        base_addr = 24'hFFFFF3;
        wait_pop(8 + 2 * HT * VT + 2 * HT);
        base_addr = 24'h000100;
        wait_pop(8 + 3 * HT * VT + 2 * HT + 11);

        rst = 1'b1;
        model_reset();
        m_next = 24'h000100;  push_n(8);
        push_n(HT * VT);
        @(negedge clk);
        rst = 1'b0;

        wait_pop(8 + 3 * HT * VT + 2 * HT + 11 + 8 + HT * VT);
        repeat (2) @(negedge clk);
        done = 1'b1;
    end

    // Monitor: owns every comparison and the summary.
    logic [23:0] prev_addr = '0;
    int          cyc = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            n_vec++;
            if (q.size() != 0) begin
                n_err++;
                $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end else if (rst) begin
            cyc       = 0;
            prev_addr = video_addr;
            n_vec++;
            if (video_addr !== 24'h0 || pixel !== 8'h0 || de !== 1'b0 || pix_ce !== 1'b0 ||
                hsync !== ~HSP || vsync !== ~VSP) begin
                n_err++;
                $display("FAIL reset_state: got addr=%06h pix=%02h de=%b ce=%b hs=%b vs=%b, required addr=000000 pix=00 de=0 ce=0 hs=%b vs=%b",
                         video_addr, pixel, de, pix_ce, hsync, vsync, ~HSP, ~VSP);
            end
        end else begin
            cyc++;
            if (video_addr !== prev_addr) begin
                n_vec++;
                if (!pix_ce) begin
                    n_err++;
                    $display("FAIL addr_stable: video_addr moved %06h->%06h without pix_ce, required change only on pix_ce",
                             prev_addr, video_addr);
                end
                prev_addr = video_addr;
            end
            if (cyc == DIV + 1) begin
                n_vec++;
                n_err++;
                $display("FAIL ce_stall: no pix_ce for %0d clks, required one every %0d", cyc, DIV);
            end
            if (pix_ce) begin
                n_vec++;
                if (cyc != DIV) begin
                    n_err++;
                    $display("FAIL ce_period: pix_ce after %0d clks, required %0d", cyc, DIV);
                end
                cyc = 0;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_pixel: pix_ce with no expected output pending, required none");
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    n_vec++;
                    if (pixel !== e.pix || de !== e.de || hsync !== e.hs || vsync !== e.vs ||
                        video_addr !== e.addr) begin
                        n_err++;
                        $display("FAIL scan h=%0d v=%0d: got pix=%02h de=%b hs=%b vs=%b addr=%06h, required pix=%02h de=%b hs=%b vs=%b addr=%06h",
                                 e.h, e.v, pixel, de, hsync, vsync, video_addr,
                                 e.pix, e.de, e.hs, e.vs, e.addr);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
